mux_sel_arbiter: RTL and testbench
==================================

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Two-requester round-robin arbiter. It drives the select input of the downstream 2:1 data mux, so only the granted source's data reaches the output.

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles before a contended grant is forcibly handed over; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  2  request vector; req[i] high = source i wants the mux.
REQ-005 Port: done  input  1  single-cycle pulse from the granted source ending its transfer.
REQ-006 Port: gnt  output  2  one-hot-or-zero grant vector, registered.
REQ-007 Port: sel  output  1  mux select; 0 = source 0, 1 = source 1, registered.
REQ-008 Port: busy  output  1  high while any grant is active.
REQ-009 Port: timeout  output  1  one-cycle pulse marking a forced handover.

Function
REQ-010 States SHALL be: IDLE, GNT0, GNT1, binary encoded; gnt = 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE.
REQ-011 sel SHALL be 0 in GNT0 and 1 in GNT1, and SHALL hold its last value in IDLE.
REQ-012 busy SHALL equal (state != IDLE).
REQ-013 A last-granted pointer `last` SHALL update to i on every entry to GNTi.
REQ-014 Latency: a request sampled at edge N SHALL produce gnt at edge N+1; no combinational path from req to gnt.
REQ-015 IDLE transitions:
- req=01 -> GNT0.
- req=10 -> GNT1.
- req=11 -> GNT(~last).
- req=00 -> stay IDLE.
REQ-016 Release condition in GNTi: done=1 or req[i]=0.
REQ-017 Release target: on release, next state SHALL be GNT(~i) if req[~i]=1, else IDLE; back-to-back handover has no idle gap.
REQ-018 Hold counter hcnt, width 8:
- loads 1 on every entry to a grant state;
- increments each cycle the grant persists;
- saturates at MAX_HOLD.
REQ-019 Forced handover: in GNTi with hcnt==MAX_HOLD, req[~i]=1 and no release condition, next state SHALL be GNT(~i) and timeout SHALL pulse high for exactly the first cycle of the new grant.
REQ-020 Uncontended grant: if req[~i]=0, the grant SHALL persist past MAX_HOLD indefinitely and timeout SHALL stay low.
REQ-021 Simultaneous events: done and forced handover in the same cycle SHALL be treated as a release; timeout stays low.
REQ-022 done asserted while in IDLE SHALL be ignored.
REQ-023 gnt SHALL never be 2'b11 in any cycle.

Reset
REQ-024 Asserting rst SHALL immediately force all of the following, with no clock required:
- state = IDLE;
- gnt = 2'b00, sel = 0, busy = 0, timeout = 0;
- hcnt = 0;
- last = 1, so source 0 wins the first contended arbitration.
REQ-025 Mid-grant reset: rst asserted during a grant SHALL drop gnt asynchronously; after rst deasserts, arbitration restarts from IDLE on the next edge.

Verification
REQ-026 Scenario: after reset, req=11 held, done pulsed on each grant's 3rd cycle -> gnt sequence 01, 10, 01, ...; sel toggles 0, 1, 0; no IDLE cycles between grants.
REQ-027 Scenario: req=01 only, held for 20 cycles, MAX_HOLD=8 -> gnt=01 for all 20 cycles; timeout never asserts; after req=00, gnt=00 one edge later.
REQ-028 Scenario: req=01, then req[1] raised on grant cycle 3, no done -> GNT0 lasts exactly 8 cycles; 9th cycle gnt=10, sel=1, timeout=1 for one cycle.
REQ-029 Scenario: done and hcnt==MAX_HOLD coincide with req=11 -> handover to GNT1 with timeout=0.
REQ-030 Scenario: rst asserted mid-edge-cycle during GNT1 -> gnt=00, busy=0 before the next clk edge; first grant after release with req=11 is GNT0.
REQ-031 Scenario: done pulsed while IDLE with req=00 -> no state change; all outputs unchanged.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1 data mux.
// Grants are registered, bounded by MAX_HOLD under contention, and released on done or request drop.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_e     state_r;
  state_e     state_s;
  logic [7:0] hcnt_r;
  logic [7:0] hcnt_s;
  logic       last_r;
  logic       last_s;
  logic       sel_s;
  logic       timeout_s;

  // Next-state arbitration, hold counter and last-granted pointer.
  always_comb begin
    state_s   = state_r;
    hcnt_s    = hcnt_r;
    last_s    = last_r;
    sel_s     = sel;
    timeout_s = 1'b0;

    case (state_r)
      IDLE: begin
        case (req)
          2'b01:   state_s = GNT0;
          2'b10:   state_s = GNT1;
          2'b11:   state_s = last_r ? GNT0 : GNT1;
          default: state_s = IDLE;
        endcase
      end
      GNT0: begin
        // A release outranks a forced handover, so done suppresses timeout.
        if (done || !req[0]) begin
          state_s = req[1] ? GNT1 : IDLE;
        end else if ((hcnt_r == MAX_HOLD_C) && req[1]) begin
          state_s   = GNT1;
          timeout_s = 1'b1;
        end else begin
          state_s = GNT0;
        end
      end
      GNT1: begin
        if (done || !req[1]) begin
          state_s = req[0] ? GNT0 : IDLE;
        end else if ((hcnt_r == MAX_HOLD_C) && req[0]) begin
          state_s   = GNT0;
          timeout_s = 1'b1;
        end else begin
          state_s = GNT1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (state_s == IDLE) begin
      hcnt_s = 8'd0;
    end else if (state_s != state_r) begin
      hcnt_s = 8'd1;
      last_s = (state_s == GNT1);
    end else if (hcnt_r < MAX_HOLD_C) begin
      hcnt_s = hcnt_r + 8'd1;
    end else begin
      hcnt_s = hcnt_r;
    end

    // sel keeps its last value while idle so the mux output stays stable.
    case (state_s)
      GNT0:    sel_s = 1'b0;
      GNT1:    sel_s = 1'b1;
      default: sel_s = sel;
    endcase
  end

  // State and registered outputs, all taken from the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      hcnt_r  <= 8'd0;
      last_r  <= 1'b1;
      gnt     <= 2'b00;
      sel     <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_r <= state_s;
      hcnt_r  <= hcnt_s;
      last_r  <= last_s;
      gnt     <= state_s;
      sel     <= sel_s;
      busy    <= (state_s != IDLE);
      timeout <= timeout_s;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed self-checking bench for mux_sel_arbiter with MAX_HOLD = 8.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic       done;
  logic [1:0] gnt;
  logic       sel;
  logic       busy;
  logic       timeout;

  int checks_r;
  int passes_r;

  mux_sel_arbiter #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  // 10-unit clock, first rising edge at t=5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks_r++;
    if (got === exp) begin
      passes_r++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] e_gnt, input logic e_sel,
                         input logic e_busy, input logic e_to);
    chk({tag, ".gnt"},     8'(gnt),     8'(e_gnt));
    chk({tag, ".sel"},     8'(sel),     8'(e_sel));
    chk({tag, ".busy"},    8'(busy),    8'(e_busy));
    chk({tag, ".timeout"}, 8'(timeout), 8'(e_to));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_r = 0;
    passes_r = 0;
    rst  = 1'b0;
    req  = 2'b00;
    done = 1'b0;

    // Asynchronous reset, observed before any clock edge.
    #2 rst = 1'b1;
    #1 chk_out("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    rst = 1'b0;

    // done while idle is ignored.
    done = 1'b1;
    tick;
    done = 1'b0;
    chk_out("idle_done", 2'b00, 1'b0, 1'b0, 1'b0);

    // Round-robin with done on each grant's third cycle: 01, 10, 01, then GNT1.
    req = 2'b11;
    tick;
    for (int g = 0; g < 3; g++) begin
      chk_out("rr_c1", (g % 2 == 1) ? 2'b10 : 2'b01, (g % 2 == 1), 1'b1, 1'b0);
      tick;
      chk("rr_c2.gnt", 8'(gnt), (g % 2 == 1) ? 8'h02 : 8'h01);
      tick;
      chk("rr_c3.gnt", 8'(gnt), (g % 2 == 1) ? 8'h02 : 8'h01);
      done = 1'b1;
      tick;
      done = 1'b0;
    end
    chk_out("rr_g4", 2'b10, 1'b1, 1'b1, 1'b0);
    req = 2'b00;
    tick;
    chk_out("rr_idle_sel_hold", 2'b00, 1'b1, 1'b0, 1'b0);

    // Uncontended grant persists past MAX_HOLD.
    req = 2'b01;
    tick;
    for (int i = 0; i < 20; i++) begin
      chk("solo.gnt", 8'(gnt), 8'h01);
      chk("solo.timeout", 8'(timeout), 8'h00);
      if (i < 19) tick;
    end
    req = 2'b00;
    tick;
    chk_out("solo_release", 2'b00, 1'b0, 1'b0, 1'b0);

    // Contention from grant cycle 3 forces handover after 8 cycles.
    req = 2'b01;
    tick;
    tick;
    tick;
    req = 2'b11;
    for (int k = 3; k <= 8; k++) begin
      chk("force_hold.gnt", 8'(gnt), 8'h01);
      chk("force_hold.timeout", 8'(timeout), 8'h00);
      tick;
    end
    chk_out("force_hand", 2'b10, 1'b1, 1'b1, 1'b1);
    tick;
    chk_out("force_after", 2'b10, 1'b1, 1'b1, 1'b0);

    // done coinciding with hcnt==MAX_HOLD is a plain release.
    for (int k = 2; k < 8; k++) tick;
    chk("coinc_pre.gnt", 8'(gnt), 8'h02);
    done = 1'b1;
    tick;
    done = 1'b0;
    chk_out("coinc_release", 2'b01, 1'b0, 1'b1, 1'b0);

    // Reset mid-grant drops outputs without a clock; restart favours source 0.
    done = 1'b1;
    tick;
    done = 1'b0;
    chk_out("pre_rst", 2'b10, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("mid_rst", 2'b00, 1'b0, 1'b0, 1'b0);
    tick;
    rst = 1'b0;
    tick;
    chk_out("post_rst", 2'b01, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes_r, checks_r);
    $finish;
  end

  // Continuous guard: the grant vector never shows both bits.
  always @(negedge clk) begin
    if (gnt === 2'b11) chk("gnt_onehot", 8'(gnt), 8'h00);
  end

endmodule
